rtc_hms_counter: RTL and testbench
==================================

Name: rtc_hms_counter

Overview:
Parametrised time-of-day counter that replaces the derived-clock seconds counter. The whole block runs in the single system clock domain and advances on a clock-enable tick, not on a generated clock. It adds 12/24-hour display, run/hold control, range-checked time load, and an hh:mm alarm with a latched flag and acknowledge. It sits between the system clock/reset and the display and alarm logic.

Parameters:
CLK_FREQ_HZ, 50_000_000, clk cycles per second. Legal range is 2 and above; benches use 4.
PRESC_W, $clog2(CLK_FREQ_HZ), prescaler width. Derived; must not be overridden.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
run  in  1  1 = prescaler counts and time advances; 0 = prescaler and time hold
mode_12h  in  1  display format: 1 = 12h, 0 = 24h
set_valid  in  1  one-cycle request to load time
set_hr  in  5  load hour, 24h format, 0..23
set_min  in  6  load minute, 0..59
set_sec  in  6  load second, 0..59
alm_wr  in  1  one-cycle request to load alarm time
alm_hr  in  5  alarm hour, 0..23
alm_min  in  6  alarm minute, 0..59
alm_en  in  1  alarm compare enable
alm_ack  in  1  clears the alarm flag
sec_tick  out  1  one-cycle pulse, once per second
hr  out  5  display hour (format per mode_12h)
min  out  6  minute
sec  out  6  second
pm  out  1  1 when internal hour is 12..23, in both modes
alarm  out  1  latched alarm flag
cfg_err  out  1  one-cycle pulse when a load request is out of range

Behaviour:
- Reset (rst=0 at a clk edge): prescaler=0, time=00:00:00, alarm registers=00:00, alarm=0, sec_tick=0, cfg_err=0. Reset overrides every other input.
- Prescaler, run=1: counts 0..CLK_FREQ_HZ-1. At terminal count it wraps to 0 and asserts sec_tick for exactly one cycle. Period is exactly CLK_FREQ_HZ cycles.
- Prescaler, run=0: prescaler holds and sec_tick stays 0.
- Time advance: in the cycle sec_tick=1, the time registers update on that same edge, so the new time is visible the cycle after the tick.
  - sec 59 -> 0 and min increments.
  - min 59 -> 0 and hr increments.
  - 23:59:59 -> 00:00:00.
- Internal hour is always 24h (hr24).
- Display hour:
  - mode_12h=0: hr = hr24.
  - mode_12h=1: hr24=0 -> 12; 1..12 -> unchanged; 13..23 -> hr24-12.
- Display outputs are combinational from the registers, with zero added latency. mode_12h may change at any time and takes effect immediately.
- Time load (set_valid=1):
  - All fields in range: time loads on the next edge and the prescaler clears to 0, so the next tick comes a full second later.
  - Load wins over a coincident tick advance.
  - Any field out of range: time and prescaler are unaffected and cfg_err pulses for one cycle.
- Alarm load (alm_wr=1): same range rules as the time load, writing the alarm registers. If set_valid and alm_wr are both asserted, each request is checked independently; cfg_err is the OR of the two failures.
- Alarm fire condition, all of:
  - a tick advance (not a load) produces a time of alm_hr:alm_min:00;
  - alm_en=1.
- When the fire condition holds, alarm is set to 1 on the same edge.
- alarm stays 1 until an edge with alm_ack=1 and no fire. Fire and ack on the same edge leave alarm=1.
- Clearing alm_en does not clear a latched alarm.
- rst=0 mid-operation clears everything, including a latched alarm and a pending prescale count.

Decomposition:
- Package rtc_pkg:
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23, HR12_NOON=12;
  - widths HR_W=5, MS_W=6;
  - range-check function for the hr/min/sec fields.
- One sub-module: rtc_tick_gen. It holds the prescaler and takes clk, rst, run and clr (load), producing sec_tick.

Test Plan:
1. Use CLK_FREQ_HZ=4. Hold rst=0 for 2 cycles, then release with run=1 -> all outputs 0. First sec_tick appears on the 4th cycle after release; sec=1 the cycle after.
2. Set 23:59:59, run=1 -> 4 cycles later time=00:00:00 and pm=0. Also load 00:59:59 -> 01:00:00 after one tick.
3. Set mode_12h=1 and load each of 00:00:00, 12:00:00 and 13:05:00 -> (hr, pm) = (12,0), (12,1) and (1,1) respectively. Switch mode_12h=0 with 13:05:00 loaded -> hr=13.
4. Load set_min=60 -> one-cycle cfg_err, time unchanged. Hold run=0 for 20 cycles -> no sec_tick, time frozen. Assert set_valid in the tick cycle -> loaded value appears, no increment.
5. Alarm 07:30 with alm_en=1, load 07:29:59 -> alarm=1 one cycle after the tick. Pulse alm_ack -> alarm=0. Re-arm and hold alm_ack through the fire edge -> alarm stays 1. Repeat with alm_en=0 -> alarm stays 0.
6. Pulse rst=0 with alarm=1 and the prescaler at 2 -> alarm=0, time 00:00:00, next tick exactly 4 cycles after release.

Source files
------------

// File: rtl/rtc_pkg.sv
// Purpose : shared widths, field limits, the time-of-day record and the
//           field range check used by the hh:mm:ss counter.
// Contents: HR_W/MS_W widths, SEC_MAX/MIN_MAX/HR_MAX/HR12_NOON limits,
//           time_t record, time_ok() range check.
package rtc_pkg;

   localparam int unsigned HR_W      = 5;
   localparam int unsigned MS_W      = 6;

   localparam int unsigned SEC_MAX   = 59;
   localparam int unsigned MIN_MAX   = 59;
   localparam int unsigned HR_MAX    = 23;
   localparam int unsigned HR12_NOON = 12;

   // Time of day, hour always held in 24h form.
   typedef struct packed {
      logic [HR_W-1:0] hr;
      logic [MS_W-1:0] min;
      logic [MS_W-1:0] sec;
   } time_t;

   // True when every field of a requested time lies in its legal range.
   function automatic logic time_ok(input time_t t);
      return (t.hr  <= HR_W'(HR_MAX))  &&
             (t.min <= MS_W'(MIN_MAX)) &&
             (t.sec <= MS_W'(SEC_MAX));
   endfunction

endpackage

// File: rtl/rtc_hms_counter_if.sv
// Purpose : control/status bundle between the time-of-day counter and
//           its user (display, alarm and configuration logic).
// Modports: master - drives run/format/load/alarm controls, reads status
//           slave  - the counter; reads controls, drives status
// Signals : run, mode_12h, set_valid/set_hr/set_min/set_sec,
//           alm_wr/alm_hr/alm_min, alm_en, alm_ack  (controls)
//           sec_tick, hr, min, sec, pm, alarm, cfg_err  (status)
interface rtc_hms_counter_if;
   import rtc_pkg::*;

   logic            run;
   logic            mode_12h;
   logic            set_valid;
   logic [HR_W-1:0] set_hr;
   logic [MS_W-1:0] set_min;
   logic [MS_W-1:0] set_sec;
   logic            alm_wr;
   logic [HR_W-1:0] alm_hr;
   logic [MS_W-1:0] alm_min;
   logic            alm_en;
   logic            alm_ack;

   logic            sec_tick;
   logic [HR_W-1:0] hr;
   logic [MS_W-1:0] min;
   logic [MS_W-1:0] sec;
   logic            pm;
   logic            alarm;
   logic            cfg_err;

   modport master (
      output run, mode_12h, set_valid, set_hr, set_min, set_sec,
             alm_wr, alm_hr, alm_min, alm_en, alm_ack,
      input  sec_tick, hr, min, sec, pm, alarm, cfg_err
   );

   modport slave (
      input  run, mode_12h, set_valid, set_hr, set_min, set_sec,
             alm_wr, alm_hr, alm_min, alm_en, alm_ack,
      output sec_tick, hr, min, sec, pm, alarm, cfg_err
   );

endinterface

// File: rtl/rtc_tick_gen.sv
// Purpose : one-second clock-enable generator. Counts system clocks while
//           run=1 and emits a registered one-cycle tick on each wrap.
// Ports   : clk  - system clock
//           rst  - synchronous reset, active low
//           run  - 1 = count, 0 = hold the prescaler
//           clr  - restart the second (time load); suppresses a pending tick
//           tick - one-cycle pulse every CLK_FREQ_HZ counted cycles
module rtc_tick_gen #(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);

   localparam int unsigned PRESC_W = $clog2(CLK_FREQ_HZ);
   localparam logic [PRESC_W-1:0] TERM = PRESC_W'(CLK_FREQ_HZ - 1);

   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic               tick_d;

   // Next prescaler value and wrap detection.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q == TERM) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + PRESC_W'(1);
         end
      end
   end

   // Prescaler and tick registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick  <= tick_d;
      end
   end

endmodule

// File: rtl/rtc_hms_counter.sv
// Purpose : time-of-day counter in the system clock domain. Advances on a
//           one-second enable, supports range-checked time load, 12/24h
//           display, and an hh:mm alarm with a latched flag and ack.
// Ports   : clk - system clock
//           rst - synchronous reset, active low
//           bus - control/status bundle (slave side):
//                 run, mode_12h, set_*, alm_*  in
//                 sec_tick, hr, min, sec, pm, alarm, cfg_err  out
//           hr/min/sec/pm are decoded combinationally from the time
//           registers so a format change shows up without delay.
module rtc_hms_counter
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   rtc_hms_counter_if.slave    bus
);

   time_t           cur_q, cur_d;
   time_t           adv;
   time_t           set_t;
   time_t           alm_t;
   logic [HR_W-1:0] alm_hr_q, alm_hr_d;
   logic [MS_W-1:0] alm_min_q, alm_min_d;
   logic            alarm_q, alarm_d;
   logic            err_q, err_d;
   logic            set_ok, alm_ok;
   logic            load, fire;
   logic            tick;
   logic [HR_W-1:0] hr_disp;

   rtc_tick_gen #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (bus.run),
      .clr  (load),
      .tick (tick)
   );

   // Request decode and range checks.
   always_comb begin
      set_t     = '{hr: bus.set_hr, min: bus.set_min, sec: bus.set_sec};
      alm_t     = '{hr: bus.alm_hr, min: bus.alm_min, sec: '0};
      set_ok    = time_ok(set_t);
      alm_ok    = time_ok(alm_t);
      load      = bus.set_valid & set_ok;
   end

   // Time one second ahead of the current registers, with carries.
   always_comb begin
      adv = cur_q;
      if (cur_q.sec == MS_W'(SEC_MAX)) begin
         adv.sec = '0;
         if (cur_q.min == MS_W'(MIN_MAX)) begin
            adv.min = '0;
            adv.hr  = (cur_q.hr == HR_W'(HR_MAX)) ? '0 : cur_q.hr + HR_W'(1);
         end else begin
            adv.min = cur_q.min + MS_W'(1);
         end
      end else begin
         adv.sec = cur_q.sec + MS_W'(1);
      end
   end

   // Next-state for time, alarm registers, alarm flag and error pulse.
   always_comb begin
      cur_d     = cur_q;
      alm_hr_d  = alm_hr_q;
      alm_min_d = alm_min_q;
      fire      = 1'b0;

      // A valid load takes priority over the tick advance.
      if (load) begin
         cur_d = set_t;
      end else if (tick) begin
         cur_d = adv;
         fire  = bus.alm_en && (adv.hr == alm_hr_q) &&
                 (adv.min == alm_min_q) && (adv.sec == '0);
      end

      if (bus.alm_wr && alm_ok) begin
         alm_hr_d  = bus.alm_hr;
         alm_min_d = bus.alm_min;
      end

      // A new fire beats a coincident acknowledge.
      alarm_d = fire | (alarm_q & ~bus.alm_ack);
      err_d   = (bus.set_valid & ~set_ok) | (bus.alm_wr & ~alm_ok);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_q     <= '0;
         alm_hr_q  <= '0;
         alm_min_q <= '0;
         alarm_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cur_q     <= cur_d;
         alm_hr_q  <= alm_hr_d;
         alm_min_q <= alm_min_d;
         alarm_q   <= alarm_d;
         err_q     <= err_d;
      end
   end

   // Display hour: 0 shows as 12, afternoon hours fold down by 12.
   always_comb begin
      hr_disp = cur_q.hr;
      if (bus.mode_12h) begin
         if (cur_q.hr == '0) begin
            hr_disp = HR_W'(HR12_NOON);
         end else if (cur_q.hr > HR_W'(HR12_NOON)) begin
            hr_disp = cur_q.hr - HR_W'(HR12_NOON);
         end
      end
   end

   assign bus.sec_tick = tick;
   assign bus.hr       = hr_disp;
   assign bus.min      = cur_q.min;
   assign bus.sec      = cur_q.sec;
   assign bus.pm       = (cur_q.hr >= HR_W'(HR12_NOON));
   assign bus.alarm    = alarm_q;
   assign bus.cfg_err  = err_q;

endmodule

// File: tb/tb_rtc_hms_counter.sv
// Bench for rtc_hms_counter at CLK_FREQ_HZ=4: directed sequences, a display
// vector table, a load range table and a random run against a seconds-of-day
// reference model.
module tb_rtc_hms_counter;

   localparam int FREQ = 4;
   localparam int DAY  = 86400;

   logic clk;
   logic rst;

   rtc_hms_counter_if bus ();

   rtc_hms_counter #(
      .CLK_FREQ_HZ (FREQ)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: time as seconds of day, alarm as minute of day.
   int m_tod  = 0;
   int m_ph   = 0;
   int m_alm  = 0;
   bit m_tick = 0;
   bit m_flag = 0;
   bit m_err  = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [20:0] model_vec();
      int h24, dh;
      h24 = m_tod / 3600;
      dh  = h24;
      if (bus.mode_12h) dh = (h24 == 0) ? 12 : ((h24 > 12) ? h24 - 12 : h24);
      return {m_tick, 5'(dh), 6'((m_tod / 60) % 60), 6'(m_tod % 60),
              (h24 >= 12), m_flag, m_err};
   endfunction

   function automatic logic [20:0] dut_vec();
      return {bus.sec_tick, bus.hr, bus.min, bus.sec, bus.pm, bus.alarm, bus.cfg_err};
   endfunction

   // One clock edge: model consumes the same inputs, then outputs compared.
   task automatic step();
      int  n_tod, n_ph, n_alm;
      bit  n_tick, n_flag, n_err, sok, aok, fire;
      n_tod = m_tod; n_ph = m_ph; n_alm = m_alm;
      n_tick = 0; n_flag = m_flag; n_err = 0; fire = 0;
      if (!rst) begin
         n_tod = 0; n_ph = 0; n_alm = 0; n_flag = 0;
      end else begin
         sok = (int'(bus.set_hr) < 24) && (int'(bus.set_min) < 60) && (int'(bus.set_sec) < 60);
         aok = (int'(bus.alm_hr) < 24) && (int'(bus.alm_min) < 60);
         if (bus.set_valid && sok) begin
            n_tod = int'(bus.set_hr) * 3600 + int'(bus.set_min) * 60 + int'(bus.set_sec);
            n_ph  = 0;
         end else begin
            if (bus.run) begin
               n_ph = m_ph + 1;
               if (n_ph == FREQ) begin
                  n_ph = 0;
                  n_tick = 1;
               end
            end
            if (m_tick) begin
               n_tod = (m_tod + 1) % DAY;
               fire  = bus.alm_en && (n_tod % 60 == 0) && (n_tod / 60 == m_alm);
            end
         end
         n_flag = fire || (m_flag && !bus.alm_ack);
         if (bus.alm_wr && aok) n_alm = int'(bus.alm_hr) * 60 + int'(bus.alm_min);
         n_err = (bus.set_valid && !sok) || (bus.alm_wr && !aok);
      end
      @(posedge clk);
      #1;
      m_tod = n_tod; m_ph = n_ph; m_alm = n_alm;
      m_tick = n_tick; m_flag = n_flag; m_err = n_err;
      cmp("state", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic do_load(input int h, input int m, input int s);
      bus.set_hr = 5'(h); bus.set_min = 6'(m); bus.set_sec = 6'(s);
      bus.set_valid = 1'b1;
      step();
      bus.set_valid = 1'b0;
   endtask

   task automatic do_alarm(input int h, input int m);
      bus.alm_hr = 5'(h); bus.alm_min = 6'(m);
      bus.alm_wr = 1'b1;
      step();
      bus.alm_wr = 1'b0;
   endtask

   // Steps until sec_tick is seen; n = edges taken, expired bound is a failure.
   task automatic wait_tick(output int n);
      n = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (bus.sec_tick) begin
            n = i;
            break;
         end
      end
      if (n == 0) cmp("tick_timeout", 32'(0), 32'(1));
   endtask

   typedef struct {
      int h; int m; int s; bit mode; int ehr; bit epm;
   } disp_vec_t;

   typedef struct {
      int h; int m; int s; bit eerr;
   } rng_vec_t;

   disp_vec_t dv[7];
   rng_vec_t  rv[6];

   initial begin
      int n;
      logic [16:0] snap;

      dv[0] = '{0, 0, 0, 1'b1, 12, 1'b0};
      dv[1] = '{12, 0, 0, 1'b1, 12, 1'b1};
      dv[2] = '{13, 5, 0, 1'b1, 1, 1'b1};
      dv[3] = '{11, 59, 0, 1'b1, 11, 1'b0};
      dv[4] = '{23, 0, 0, 1'b1, 11, 1'b1};
      dv[5] = '{1, 0, 0, 1'b1, 1, 1'b0};
      dv[6] = '{13, 5, 0, 1'b0, 13, 1'b1};

      rv[0] = '{0, 60, 0, 1'b1};
      rv[1] = '{24, 0, 0, 1'b1};
      rv[2] = '{0, 0, 60, 1'b1};
      rv[3] = '{23, 59, 59, 1'b0};
      rv[4] = '{31, 63, 63, 1'b1};
      rv[5] = '{0, 0, 0, 1'b0};

      rst = 1'b0;
      bus.run = 1'b1; bus.mode_12h = 1'b0;
      bus.set_valid = 1'b0; bus.set_hr = '0; bus.set_min = '0; bus.set_sec = '0;
      bus.alm_wr = 1'b0; bus.alm_hr = '0; bus.alm_min = '0;
      bus.alm_en = 1'b0; bus.alm_ack = 1'b0;

      // Reset and first tick latency.
      step();
      step();
      cmp("reset_zero", 32'(dut_vec()), 32'(0));
      rst = 1'b1;
      wait_tick(n);
      cmp("first_tick_lat", 32'(n), 32'(4));
      step();
      cmp("sec_after_tick", 32'(bus.sec), 32'(1));

      // Day and hour rollover.
      do_load(23, 59, 59);
      wait_tick(n);
      cmp("load_tick_lat", 32'(n), 32'(4));
      step();
      cmp("day_wrap", 32'({bus.hr, bus.min, bus.sec, bus.pm}), 32'({5'd0, 6'd0, 6'd0, 1'b0}));
      do_load(0, 59, 59);
      wait_tick(n);
      step();
      cmp("hour_wrap", 32'({bus.hr, bus.min, bus.sec}), 32'({5'd1, 6'd0, 6'd0}));

      // Display format table.
      for (int i = 0; i < 7; i++) begin
         bus.mode_12h = dv[i].mode;
         do_load(dv[i].h, dv[i].m, dv[i].s);
         cmp("disp_hr", 32'(bus.hr), 32'(dv[i].ehr));
         cmp("disp_pm", 32'(bus.pm), 32'(dv[i].epm));
      end
      bus.mode_12h = 1'b1;
      #1;
      cmp("mode_12h_now", 32'(bus.hr), 32'(1));
      bus.mode_12h = 1'b0;
      #1;
      cmp("mode_24h_now", 32'(bus.hr), 32'(13));

      // Load range table, prescaler frozen.
      bus.run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         snap = {bus.hr, bus.min, bus.sec};
         do_load(rv[i].h, rv[i].m, rv[i].s);
         cmp("rng_err", 32'(bus.cfg_err), 32'(rv[i].eerr));
         if (rv[i].eerr)
            cmp("rng_keep", 32'({bus.hr, bus.min, bus.sec}), 32'(snap));
         else
            cmp("rng_load", 32'({bus.hr, bus.min, bus.sec}), 32'({5'(rv[i].h), 6'(rv[i].m), 6'(rv[i].s)}));
         step();
         cmp("err_one_cycle", 32'(bus.cfg_err), 32'(0));
      end

      // Hold: 20 cycles frozen.
      do_load(5, 6, 7);
      for (int i = 0; i < 20; i++) begin
         step();
         cmp("hold_no_tick", 32'(bus.sec_tick), 32'(0));
      end
      cmp("hold_frozen", 32'({bus.hr, bus.min, bus.sec}), 32'({5'd5, 6'd6, 6'd7}));

      // Load during the tick cycle wins over the advance.
      bus.run = 1'b1;
      wait_tick(n);
      do_load(10, 20, 30);
      cmp("load_beats_tick", 32'({bus.hr, bus.min, bus.sec}), 32'({5'd10, 6'd20, 6'd30}));

      // Bad alarm write with a good time load in the same cycle.
      bus.alm_hr = 5'd24; bus.alm_min = 6'd0; bus.alm_wr = 1'b1;
      do_load(2, 3, 4);
      bus.alm_wr = 1'b0;
      cmp("dual_err", 32'({bus.cfg_err, bus.hr, bus.min, bus.sec}), 32'({1'b1, 5'd2, 6'd3, 6'd4}));

      // Alarm fire, ack, fire-with-ack, enable cleared after fire.
      bus.alm_en = 1'b1;
      do_alarm(7, 30);
      do_load(7, 29, 59);
      wait_tick(n);
      cmp("alarm_pre", 32'(bus.alarm), 32'(0));
      step();
      cmp("alarm_fire", 32'(bus.alarm), 32'(1));
      bus.alm_en = 1'b0;
      step();
      cmp("alarm_en_off_hold", 32'(bus.alarm), 32'(1));
      bus.alm_ack = 1'b1;
      step();
      bus.alm_ack = 1'b0;
      cmp("alarm_ack", 32'(bus.alarm), 32'(0));
      bus.alm_en = 1'b1;
      do_load(7, 29, 59);
      wait_tick(n);
      bus.alm_ack = 1'b1;
      step();
      bus.alm_ack = 1'b0;
      cmp("alarm_fire_ack", 32'(bus.alarm), 32'(1));
      bus.alm_ack = 1'b1;
      step();
      bus.alm_ack = 1'b0;
      bus.alm_en = 1'b0;
      do_load(7, 29, 59);
      wait_tick(n);
      step();
      cmp("alarm_disabled", 32'(bus.alarm), 32'(0));

      // Reset with alarm latched and prescaler at 2.
      bus.alm_en = 1'b1;
      do_load(7, 29, 59);
      wait_tick(n);
      step();
      step();
      cmp("pre_rst_alarm", 32'(bus.alarm), 32'(1));
      rst = 1'b0;
      step();
      rst = 1'b1;
      cmp("mid_rst", 32'(dut_vec()), 32'(0));
      wait_tick(n);
      cmp("rst_tick_lat", 32'(n), 32'(4));

      // Random run against the model.
      for (int i = 0; i < 3000; i++) begin
         bus.run       = ($urandom_range(0, 7) != 0);
         bus.mode_12h  = 1'($urandom_range(0, 1));
         bus.alm_en    = ($urandom_range(0, 3) != 0);
         bus.alm_ack   = ($urandom_range(0, 15) == 0);
         bus.set_valid = ($urandom_range(0, 23) == 0);
         bus.set_hr    = 5'($urandom_range(0, 25));
         bus.set_min   = 6'($urandom_range(0, 61));
         bus.set_sec   = 6'($urandom_range(54, 61));
         bus.alm_wr    = bus.set_valid | ($urandom_range(0, 63) == 0);
         bus.alm_hr    = bus.set_hr;
         bus.alm_min   = 6'(int'(bus.set_min) + 1);
         rst           = ($urandom_range(0, 499) != 0);
         step();
      end
      rst = 1'b1;
      bus.set_valid = 1'b0;
      bus.alm_wr = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
